// File: rtl/btn_led_ctrl.sv
// Multi-channel push-button front end: sync, debounce, press-edge detect, per-channel LED mode.
// Latency: press pulses DEBOUNCE_CYCLES+2 edges after btn is first sampled; led updates one edge later.
// Backpressure: none; free-running datapath, press is a fire-and-forget one-cycle pulse.
module btn_led_ctrl #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int BLINK_HALF      = 3000000,
  parameter int PULSE_CYCLES    = 6000000
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [N_CH-1:0]   btn,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   press
);

  // Counter widths; the blink counter needs at least one bit even when it wraps every cycle.
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int OW = $clog2(PULSE_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [OW-1:0] OC_LOAD    = OW'(PULSE_CYCLES);

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_MOMENT  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic [BW-1:0] blink_cnt;
  logic          phase;

  // Shared blink square wave: phase flips every BLINK_HALF cycles.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          db;
    logic          db_q;
    logic [DW-1:0] cnt;
    logic          press_r;
    logic          st;
    logic          st_n;
    logic [OW-1:0] oc;
    logic [OW-1:0] oc_n;
    logic          led_r;
    logic          led_n;
    logic [1:0]    mode_q;
    logic          mode_chg;
    mode_e         mode_i;

    assign mode_i   = mode_e'(mode[2*i +: 2]);
    assign mode_chg = (mode[2*i +: 2] != mode_q);

    // Two-flop synchroniser plus debounce: a new level must hold DEBOUNCE_CYCLES cycles.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        db  <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= btn[i];
        s2 <= s1;
        if (s2 == db) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Rising edge of the debounced level becomes a registered one-cycle press pulse.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        db_q    <= 1'b0;
        press_r <= 1'b0;
      end else begin
        db_q    <= db;
        press_r <= db & ~db_q;
      end
    end

    // Next-state and next-LED per mode; a mode change clears state and swallows a coincident press.
    always_comb begin
      st_n  = st;
      oc_n  = oc;
      led_n = 1'b0;
      if (mode_chg) begin
        st_n  = 1'b0;
        oc_n  = '0;
        led_n = 1'b0;
      end else begin
        case (mode_i)
          MODE_TOGGLE: begin
            st_n  = st ^ press_r;
            oc_n  = '0;
            led_n = st ^ press_r;
          end
          MODE_MOMENT: begin
            st_n  = 1'b0;
            oc_n  = '0;
            led_n = db;
          end
          MODE_BLINK: begin
            st_n  = st ^ press_r;
            oc_n  = '0;
            led_n = (st ^ press_r) & phase;
          end
          MODE_ONESHOT: begin
            st_n = 1'b0;
            if (press_r) begin
              oc_n = OC_LOAD;
            end else if (oc != '0) begin
              oc_n = oc - 1'b1;
            end
            led_n = (oc_n != '0);
          end
          default: begin
            st_n  = 1'b0;
            oc_n  = '0;
            led_n = 1'b0;
          end
        endcase
      end
    end

    // Mode state, one-shot counter, registered LED and previous-mode tracking.
    always_ff @(posedge sysclk) begin
      if (rst) begin
        st     <= 1'b0;
        oc     <= '0;
        led_r  <= 1'b0;
        mode_q <= 2'b00;
      end else begin
        st     <= st_n;
        oc     <= oc_n;
        led_r  <= led_n;
        mode_q <= mode[2*i +: 2];
      end
    end

    assign press[i] = press_r;
    assign led[i]   = led_r;
  end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl: reset, debounce, bounce, momentary/blink, one-shot retrigger, mode change.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: not applicable; a second instance with a longer one-shot exercises retrigger.
module tb_btn_led_ctrl;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [3:0] mode;
  logic [1:0] led;
  logic [1:0] press;
  logic [1:0] led_l;
  logic [1:0] press_l;

  int n_checks = 0;
  int n_fail   = 0;

  btn_led_ctrl #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .BLINK_HALF(3), .PULSE_CYCLES(5)
  ) u_dut (
    .sysclk(sysclk), .rst(rst), .btn(btn), .mode(mode), .led(led), .press(press)
  );

  // Same configuration but a 10-cycle one-shot, long enough for a retrigger to land with oc=2.
  btn_led_ctrl #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .BLINK_HALF(3), .PULSE_CYCLES(10)
  ) u_dut_long (
    .sysclk(sysclk), .rst(rst), .btn(btn), .mode(mode), .led(led_l), .press(press_l)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input logic [3:0] m);
    rst = 1'b1; btn = 2'b00; mode = m;
    ticks(2);
    rst = 1'b0;
    ticks(2);
  endtask

  task automatic test_reset();
    logic [1:0] exp_p;
    rst = 1'b1; btn = 2'b11; mode = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (led !== 2'b00 || press !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: led=%b press=%b, expected 00/00", k, led, press);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_p = (k == 7) ? 2'b11 : 2'b00;
      n_checks++;
      if (press !== exp_p) begin
        n_fail++;
        $display("FAIL reset_release_press cyc%0d: press=%b, expected %b", k, press, exp_p);
      end
    end
    n_checks++;
    if (led !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_led: led=%b, expected 11", led);
    end
    btn = 2'b00;
    ticks(8);
    n_checks++;
    if (led !== 2'b11) begin
      n_fail++;
      $display("FAIL release_no_toggle: led=%b, expected 11", led);
    end
  endtask

  task automatic test_debounce();
    logic [1:0] exp_p;
    do_reset(4'b0000);
    btn = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_checks++;
      if (press !== 2'b00) begin
        n_fail++;
        $display("FAIL short_pulse_press cyc%0d: press=%b, expected 00", k, press);
      end
      if (k == 3) btn = 2'b00;
    end
    n_checks++;
    if (led !== 2'b00) begin
      n_fail++;
      $display("FAIL short_pulse_led: led=%b, expected 00", led);
    end
    for (int pass = 0; pass < 2; pass++) begin
      btn = 2'b01;
      for (int k = 1; k <= 10; k++) begin
        tick();
        exp_p = (k == 7) ? 2'b01 : 2'b00;
        n_checks++;
        if (press !== exp_p) begin
          n_fail++;
          $display("FAIL clean_press%0d cyc%0d: press=%b, expected %b", pass, k, press, exp_p);
        end
        if (k == 8) begin
          n_checks++;
          if (led[0] !== (pass == 0)) begin
            n_fail++;
            $display("FAIL toggle%0d_led: led0=%b, expected %b", pass, led[0], (pass == 0));
          end
          btn = 2'b00;
        end
      end
      ticks(10);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    logic [1:0] exp_p;
    pat = 8'b1111_0111;
    do_reset(4'b0000);
    for (int k = 1; k <= 14; k++) begin
      btn[0] = (k <= 8) ? pat[k-1] : 1'b1;
      tick();
      exp_p = (k == 11) ? 2'b01 : 2'b00;
      n_checks++;
      if (press !== exp_p) begin
        n_fail++;
        $display("FAIL bounce_press cyc%0d: press=%b, expected %b", k, press, exp_p);
      end
      if (k == 12) begin
        n_checks++;
        if (led[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bounce_led: led0=%b, expected 1", led[0]);
        end
      end
    end
    btn = 2'b00;
    ticks(8);
  endtask

  task automatic test_momentary_blink();
    logic exp_l;
    logic prev;
    logic found;
    do_reset(4'b1001);
    btn = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_l = (k >= 7 && k <= 16);
      n_checks++;
      if (led[0] !== exp_l || led[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL momentary cyc%0d: led=%b, expected 0%b", k, led, exp_l);
      end
      if (k == 10) btn = 2'b00;
    end
    btn = 2'b10;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) begin
        n_checks++;
        if (press[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL blink_press: press1=%b, expected 1", press[1]);
        end
        btn = 2'b00;
      end
    end
    prev  = led[1];
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (led[1] === 1'b1 && prev === 1'b0) found = 1'b1;
      prev = led[1];
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL blink_rise: no led1 rise within 12 cycles, expected one");
    end
    for (int j = 1; j <= 11; j++) begin
      tick();
      exp_l = ((j % 6) < 3);
      n_checks++;
      if (led[1] !== exp_l) begin
        n_fail++;
        $display("FAIL blink_wave j%0d: led1=%b, expected %b", j, led[1], exp_l);
      end
    end
    btn = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 7) btn = 2'b00;
      if (k >= 8) begin
        n_checks++;
        if (led[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL blink_off cyc%0d: led1=%b, expected 0", k, led[1]);
        end
      end
    end
  endtask

  task automatic test_oneshot_retrigger();
    logic exp_p;
    logic exp_l;
    logic exp_ll;
    do_reset(4'b0011);
    for (int k = 1; k <= 30; k++) begin
      btn[0] = (k <= 5) || (k >= 10 && k <= 20);
      tick();
      exp_p  = (k == 7 || k == 16);
      exp_l  = (k >= 8 && k <= 12) || (k >= 17 && k <= 21);
      exp_ll = (k >= 8 && k <= 26);
      n_checks++;
      if (press[0] !== exp_p) begin
        n_fail++;
        $display("FAIL oneshot_press cyc%0d: press0=%b, expected %b", k, press[0], exp_p);
      end
      n_checks++;
      if (led[0] !== exp_l) begin
        n_fail++;
        $display("FAIL oneshot_led cyc%0d: led0=%b, expected %b", k, led[0], exp_l);
      end
      n_checks++;
      if (led_l[0] !== exp_ll) begin
        n_fail++;
        $display("FAIL retrigger_led cyc%0d: led0=%b, expected %b", k, led_l[0], exp_ll);
      end
    end
    btn = 2'b00;
    ticks(8);
  endtask

  task automatic test_mode_change();
    logic [1:0] exp_p;
    do_reset(4'b0000);
    for (int k = 1; k <= 8; k++) begin
      btn[0] = (k <= 6);
      tick();
    end
    ticks(8);
    n_checks++;
    if (led[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_pre: led0=%b, expected 1", led[0]);
    end
    mode = 4'b0010;
    tick();
    n_checks++;
    if (led[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_clear: led0=%b, expected 0", led[0]);
    end
    tick();
    n_checks++;
    if (led[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_stay: led0=%b, expected 0", led[0]);
    end
    for (int k = 1; k <= 9; k++) begin
      btn = (k <= 6) ? 2'b11 : 2'b00;
      tick();
      exp_p = (k == 7) ? 2'b11 : 2'b00;
      n_checks++;
      if (press !== exp_p) begin
        n_fail++;
        $display("FAIL simul_press cyc%0d: press=%b, expected %b", k, press, exp_p);
      end
      if (k == 8) begin
        n_checks++;
        if (led[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL simul_led1: led1=%b, expected 1", led[1]);
        end
      end
    end
    ticks(8);
    for (int k = 1; k <= 12; k++) begin
      btn[1] = (k <= 6);
      tick();
      if (k == 7) begin
        n_checks++;
        if (press[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL mc_press_coincide: press1=%b, expected 1", press[1]);
        end
        mode = 4'b1110;
      end
      if (k >= 8) begin
        n_checks++;
        if (led[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL mc_press_ignored cyc%0d: led1=%b, expected 0", k, led[1]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_debounce();
    test_bounce();
    test_momentary_blink();
    test_oneshot_retrigger();
    test_mode_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
